// File: rtl/wb_i2c_cmdq.sv
// wb_i2c_cmdq: Wishbone pipelined slave that queues I2C byte commands for the byte engine.
//
// Purpose:
//   Accepts 32-bit register writes from the AXI-lite-to-Wishbone bridge, pushes
//   TXCMD words into a first-word-fall-through FIFO, and offers them to the I2C
//   byte engine as a valid/ready stream. Also exposes CTRL and STATUS registers.
//
// Register map (word address, upper bits must be zero):
//   0 TXCMD  W: push {rd,stop,start,byte} = data[10:0] when sel[1:0]==2'b11; R: 0
//   1 CTRL   RW: [0] enable, [1] flush (write-1 action, reads 0), [2] irq_en
//   2 STATUS R: [0] empty, [1] full, [8 +: LGFIFO+1] fill count; W: error
//   3 -      error
//
// Ports:
//   i_clk, w_reset                 clock, synchronous active-high reset
//   i_wb_cyc/stb/we/addr/data/sel  Wishbone request
//   o_wb_stall/ack/err/data        Wishbone response (ack/err one cycle after acceptance)
//   o_cmd_valid, i_cmd_ready       command stream handshake
//   o_cmd_byte/start/stop/rd       command fields, read from the FIFO head
//   o_irq                          registered level interrupt: queue drained
module wb_i2c_cmdq #(
    parameter int AW     = 26,
    parameter int DW     = 32,
    parameter int LGFIFO = 4
) (
    input  logic            i_clk,
    input  logic            w_reset,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic [DW-1:0]   i_wb_data,
    input  logic [DW/8-1:0] i_wb_sel,
    output logic            o_wb_stall,
    output logic            o_wb_ack,
    output logic            o_wb_err,
    output logic [DW-1:0]   o_wb_data,
    output logic            o_cmd_valid,
    input  logic            i_cmd_ready,
    output logic [7:0]      o_cmd_byte,
    output logic            o_cmd_start,
    output logic            o_cmd_stop,
    output logic            o_cmd_rd,
    output logic            o_irq
);
    localparam int DEPTH = 1 << LGFIFO;

    logic [10:0]     mem [DEPTH];
    logic [LGFIFO:0] wr_q, wr_d, rd_q, rd_d, fill;
    logic            enable_q, enable_d, irq_en_q, irq_en_d;
    logic            ack_q, ack_d, err_q, err_d, irq_q, irq_d;
    logic [DW-1:0]   data_q, data_d, rdata, status;
    logic [1:0]      a;
    logic            upper_zero, accept, bad, empty, full, push, pop, ctrl_wr, flush;
    logic            unused;

    assign a          = i_wb_addr[1:0];
    assign upper_zero = ~|i_wb_addr[AW-1:2];
    assign empty      = wr_q == rd_q;
    assign full       = (wr_q[LGFIFO] != rd_q[LGFIFO]) && (wr_q[LGFIFO-1:0] == rd_q[LGFIFO-1:0]);
    assign fill       = wr_q - rd_q;
    // Stall looks only at full: a same-cycle pop does not free a slot until the next cycle.
    assign o_wb_stall = i_wb_stb && i_wb_we && a == 2'd0 && upper_zero && full;
    assign accept     = i_wb_cyc && i_wb_stb && !o_wb_stall;
    assign bad        = !upper_zero || a == 2'd3 || (a == 2'd2 && i_wb_we);
    assign push       = accept && i_wb_we && !bad && a == 2'd0 && i_wb_sel[1:0] == 2'b11;
    assign ctrl_wr    = accept && i_wb_we && !bad && a == 2'd1 && i_wb_sel[0];
    assign flush      = ctrl_wr && i_wb_data[1];
    assign o_cmd_valid = enable_q && !empty;
    assign pop        = o_cmd_valid && i_cmd_ready;
    assign {o_cmd_rd, o_cmd_stop, o_cmd_start, o_cmd_byte} = mem[rd_q[LGFIFO-1:0]];
    assign o_wb_ack   = ack_q;
    assign o_wb_err   = err_q;
    assign o_wb_data  = data_q;
    assign o_irq      = irq_q;
    assign unused     = ^{i_wb_sel[DW/8-1:2], i_wb_data[DW-1:11]};

    always_comb begin
        status = '0;
        status[0] = empty;
        status[1] = full;
        status[8 +: LGFIFO+1] = fill;
    end

    assign rdata = a == 2'd1 ? DW'({irq_en_q, 1'b0, enable_q}) : a == 2'd2 ? status : '0;

    always_comb begin
        // Flush wins over any pop or push in the same cycle.
        wr_d     = flush ? '0 : wr_q + (LGFIFO+1)'(push);
        rd_d     = flush ? '0 : rd_q + (LGFIFO+1)'(pop);
        enable_d = ctrl_wr ? i_wb_data[0] : enable_q;
        irq_en_d = ctrl_wr ? i_wb_data[2] : irq_en_q;
        ack_d    = accept && !bad;
        err_d    = accept && bad;
        data_d   = (accept && !bad && !i_wb_we) ? rdata : '0;
        irq_d    = irq_en_q && enable_q && empty;
    end

    always_ff @(posedge i_clk) begin
        if (w_reset) begin
            wr_q     <= '0;
            rd_q     <= '0;
            enable_q <= 1'b0;
            irq_en_q <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            enable_q <= enable_d;
            irq_en_q <= irq_en_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            data_q   <= data_d;
            irq_q    <= irq_d;
        end
    end

    // FIFO storage is intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_q[LGFIFO-1:0]] <= i_wb_data[10:0];
    end
endmodule

// File: tb/tb_wb_i2c_cmdq.sv
// tb_wb_i2c_cmdq: directed and randomized bench for wb_i2c_cmdq against a queue-based model.
module tb_wb_i2c_cmdq;
    logic        clk = 0;
    logic        w_reset = 1;
    logic        cyc = 0, stb = 0, we = 0;
    logic [25:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  sel = '0;
    logic        stall, ack, err;
    logic [31:0] rdata;
    logic        valid, ready = 0;
    logic [7:0]  cbyte;
    logic        cstart, cstop, crd, irq;

    int vectors = 0;
    int miscompares = 0;

    logic [10:0] q[$];
    logic        m_en = 0, m_irq_en = 0;

    wb_i2c_cmdq dut (
        .i_clk(clk), .w_reset(w_reset),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
        .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_err(err), .o_wb_data(rdata),
        .o_cmd_valid(valid), .i_cmd_ready(ready), .o_cmd_byte(cbyte),
        .o_cmd_start(cstart), .o_cmd_stop(cstop), .o_cmd_rd(crd), .o_irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        int n = q.size();
        return (32'(n) << 8) | ((n == 16) ? 32'h2 : 32'h0) | ((n == 0) ? 32'h1 : 32'h0);
    endfunction

    // One request; returns at the negedge of the response cycle.
    task automatic wb(input logic w, input logic [25:0] ad, input logic [31:0] d, input logic [3:0] s,
                      output logic o_ack, output logic o_err, output logic [31:0] o_dat);
        int k;
        @(negedge clk);
        cyc = 1; stb = 1; we = w; addr = ad; wdata = d; sel = s;
        #1;
        for (k = 0; k < 50 && stall; k++) begin
            @(negedge clk);
            #1;
        end
        if (k == 50) chk("stall_timeout", 32'(stall), 0);
        @(negedge clk);
        o_ack = ack; o_err = err; o_dat = rdata;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wr_ok(input string tag, input logic [25:0] ad, input logic [31:0] d, input logic [3:0] s);
        logic a, e; logic [31:0] r;
        wb(1, ad, d, s, a, e, r);
        chk({tag, "_ack"}, {a, e}, 2'b10);
        if (ad == 0 && s[1:0] == 2'b11) q.push_back(d[10:0]);
        if (ad == 1 && s[0]) begin
            m_en = d[0]; m_irq_en = d[2];
            if (d[1]) q.delete();
        end
    endtask

    task automatic rd_chk(input string tag, input logic [25:0] ad, input logic [31:0] exp);
        logic a, e; logic [31:0] r;
        wb(0, ad, 0, 4'hF, a, e, r);
        chk({tag, "_ack"}, {a, e}, 2'b10);
        chk({tag, "_data"}, r, exp);
    endtask

    task automatic err_chk(input string tag, input logic w, input logic [25:0] ad);
        logic a, e; logic [31:0] r;
        wb(w, ad, 32'h0000_0706, 4'hF, a, e, r);
        chk({tag, "_resp"}, {a, e}, 2'b01);
    endtask

    initial begin
        logic [10:0] d;
        logic        full_m;
        int          pushed;
        logic        exp_ack;

        // Reset state
        repeat (2) @(negedge clk);
        w_reset = 0;
        #1;
        chk("rst_outs", {ack, err, valid, irq, stall}, 5'b0);
        chk("rst_data", rdata, 0);
        rd_chk("rst_status", 2, 32'h1);
        rd_chk("rst_ctrl", 1, 32'h0);

        // Queue one command
        wr_ok("en", 1, 32'h1, 4'hF);
        wr_ok("tx1", 0, 32'h0000_03A5, 4'hF);
        chk("tx1_valid", 32'(valid), 1);
        chk("tx1_cmd", {crd, cstop, cstart, cbyte}, 11'h3A5);
        ready = 1;
        @(negedge clk);
        ready = 0;
        void'(q.pop_front());
        #1;
        chk("tx1_popped", 32'(valid), 0);
        rd_chk("tx1_status", 2, m_status());
        rd_chk("txcmd_read", 0, 0);

        // Partial byte select writes are acked but queue nothing
        wr_ok("sel_partial", 0, 32'h0000_01FF, 4'h1);
        rd_chk("sel_status", 2, m_status());

        // Dropped cycle: strobe without cyc is ignored
        @(negedge clk);
        stb = 1; we = 0; addr = 1;
        @(negedge clk);
        chk("drop_resp", {ack, err}, 2'b00);
        stb = 0;

        // Error paths leave CTRL and FIFO untouched
        err_chk("err_wstat", 1, 2);
        err_chk("err_r3", 0, 3);
        err_chk("err_w3", 1, 3);
        err_chk("err_hi", 1, 26'h10);
        rd_chk("err_ctrl", 1, 32'h1);
        rd_chk("err_status", 2, m_status());

        // Fill to full with the engine disabled
        wr_ok("dis", 1, 32'h0, 4'hF);
        for (int i = 0; i < 16; i++) wr_ok("fill", 0, 32'($urandom_range(0, 2047)), 4'hF);
        rd_chk("full_status", 2, 32'h0000_1002);
        ready = 1;
        wr_ok("en2", 1, 32'h1, 4'hF);
        chk("full_head", {crd, cstop, cstart, cbyte}, q[0]);
        d = 11'($urandom_range(0, 2047));
        cyc = 1; stb = 1; we = 1; addr = 0; wdata = 32'(d); sel = 4'hF;
        #1;
        chk("full_stall", 32'(stall), 1);
        @(negedge clk);
        void'(q.pop_front());
        ready = 0;
        #1;
        chk("stall_release", 32'(stall), 0);
        @(negedge clk);
        chk("tx17_ack", {ack, err}, 2'b10);
        cyc = 0; stb = 0; we = 0;
        q.push_back(d);
        rd_chk("tx17_status", 2, m_status());

        // Random push/pop with wrap: output order must match input order
        pushed = 0;
        exp_ack = 0;
        for (int c = 0; c < 600 && (pushed < 40 || q.size() > 0); c++) begin
            @(negedge clk);
            chk("rnd_ack", 32'(ack), 32'(exp_ack));
            d = 11'($urandom_range(0, 2047));
            cyc = (pushed < 40) && ($urandom_range(0, 1) == 1);
            stb = cyc; we = 1; addr = 0; wdata = 32'(d); sel = 4'hF;
            ready = $urandom_range(0, 1) == 1;
            #1;
            full_m = q.size() == 16;
            chk("rnd_stall", 32'(stall), 32'(stb && full_m));
            chk("rnd_valid", 32'(valid), 32'(q.size() != 0));
            if (q.size() != 0) chk("rnd_cmd", {crd, cstop, cstart, cbyte}, q[0]);
            if (q.size() != 0 && ready) void'(q.pop_front());
            exp_ack = stb && !full_m;
            if (exp_ack) begin
                q.push_back(d);
                pushed++;
            end
        end
        @(negedge clk);
        chk("rnd_last_ack", 32'(ack), 32'(exp_ack));
        cyc = 0; stb = 0; we = 0; ready = 0;
        chk("rnd_done", {pushed, q.size()}, {32'd40, 32'd0});
        rd_chk("rnd_status", 2, m_status());

        // Flush and IRQ
        wr_ok("dis3", 1, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) wr_ok("q3", 0, 32'($urandom_range(0, 2047)), 4'hF);
        rd_chk("q3_status", 2, m_status());
        wr_ok("flush", 1, 32'h7, 4'hF);
        chk("flush_empty", {valid, irq}, 2'b00);
        @(negedge clk);
        chk("irq_set", 32'(irq), 1);
        rd_chk("ctrl_rd", 1, 32'h5);
        rd_chk("flush_status", 2, m_status());
        wr_ok("irq_push", 0, 32'h0000_0142, 4'hF);
        chk("irq_valid", {valid, crd, cstop, cstart, cbyte}, 12'h942);
        @(negedge clk);
        chk("irq_drop", 32'(irq), 0);

        // Disable holds contents and drops valid
        wr_ok("dis4", 1, 32'h4, 4'hF);
        chk("dis_valid", 32'(valid), 0);
        rd_chk("dis_status", 2, m_status());

        // Reset mid-burst
        for (int i = 0; i < 4; i++) wr_ok("q5", 0, 32'($urandom_range(0, 2047)), 4'hF);
        rd_chk("q5_status", 2, 32'h0000_0500);
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; addr = 1; w_reset = 1;
        @(negedge clk);
        cyc = 0; stb = 0; w_reset = 0;
        q.delete();
        m_en = 0; m_irq_en = 0;
        #1;
        chk("rst2_outs", {ack, err, valid, irq, stall}, 5'b0);
        chk("rst2_data", rdata, 0);
        rd_chk("rst2_status", 2, m_status());
        rd_chk("rst2_ctrl", 1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
